// File: rtl/uart_apb_pkg.sv
// Shared constants for the UART APB host: register indices, STATUS/CTRL bit
// positions and the access FSM encoding.
package uart_apb_pkg;

   localparam logic [1:0] REG_DATA     = 2'd0;
   localparam logic [1:0] REG_STATUS   = 2'd1;
   localparam logic [1:0] REG_CTRL     = 2'd2;
   localparam logic [1:0] REG_UNMAPPED = 2'd3;

   localparam int ST_RX_AVAIL = 0;
   localparam int ST_TX_FULL  = 1;
   localparam int ST_BUSY     = 2;
   localparam int ST_RX_OVR   = 3;
   localparam int ST_TX_ERR   = 4;

   localparam int CTRL_RX_IE  = 0;
   localparam int CTRL_ERR_IE = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RD_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/uart_apb_host_if.sv
// APB slave bundle for the UART host; DATA_W must match the attached host.
interface uart_apb_host_if #(
   parameter int DATA_W = 16
);
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [1:0]        paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/uart_apb_host.sv
// APB register front-end for a UART FIFO pair: DATA/STATUS/CTRL registers,
// one-wait-state RX reads, TX write pulses and a maskable interrupt.
module uart_apb_host
   import uart_apb_pkg::*;
#(
   parameter int         DATA_W     = 16,
   parameter logic [1:0] IRQ_EN_RST = 2'b00
) (
   input  logic                  clk,
   input  logic                  rst_n,
   uart_apb_host_if.slave        apb,
   output logic [7:0]            tx_byte,
   output logic                  transmit,
   output logic                  rx_fifo_pop,
   input  logic [7:0]            rx_byte,
   input  logic                  rx_fifo_empty,
   input  logic                  tx_fifo_full,
   input  logic                  busy,
   input  logic                  uart_irq,
   output logic                  irq
);

   state_t            state_q, state_d;
   logic [7:0]        hold_q;
   logic [1:0]        ctrl_q;
   logic              rx_ovr_q, tx_err_q;
   logic [DATA_W-1:0] rdata;
   logic              ready, slverr, pop;
   logic              hold_ld, wr_tx, ctrl_wr, tx_err_set, ovr_clr, err_clr;
   logic              access, ovr_set;
   logic              unused_pwdata;

   assign access        = apb.psel & apb.penable;
   assign unused_pwdata = ^apb.pwdata;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d    = state_q;
      rdata      = '0;
      ready      = 1'b0;
      slverr     = 1'b0;
      pop        = 1'b0;
      hold_ld    = 1'b0;
      wr_tx      = 1'b0;
      ctrl_wr    = 1'b0;
      tx_err_set = 1'b0;
      ovr_clr    = 1'b0;
      err_clr    = 1'b0;
      unique case (state_q)
         IDLE: if (access) begin
            if (!apb.pwrite && apb.paddr == REG_DATA && !rx_fifo_empty) begin
               state_d = RD_WAIT;
               hold_ld = 1'b1;
            end else begin
               ready = 1'b1;
               case (apb.paddr)
                  REG_DATA: begin
                     if (!apb.pwrite)       slverr = 1'b1;
                     else if (tx_fifo_full) begin
                        slverr     = 1'b1;
                        tx_err_set = 1'b1;
                     end else               wr_tx  = 1'b1;
                  end
                  REG_STATUS: begin
                     if (apb.pwrite) begin
                        ovr_clr = apb.pwdata[ST_RX_OVR];
                        err_clr = apb.pwdata[ST_TX_ERR];
                     end else begin
                        rdata[ST_RX_AVAIL] = ~rx_fifo_empty;
                        rdata[ST_TX_FULL]  = tx_fifo_full;
                        rdata[ST_BUSY]     = busy;
                        rdata[ST_RX_OVR]   = rx_ovr_q;
                        rdata[ST_TX_ERR]   = tx_err_q;
                     end
                  end
                  REG_CTRL: begin
                     if (apb.pwrite) ctrl_wr    = 1'b1;
                     else            rdata[1:0] = ctrl_q;
                  end
                  REG_UNMAPPED: slverr = 1'b1;
               endcase
            end
         end
         // The hold register decouples prdata from the FIFO head that the pop is about to advance.
         RD_WAIT: begin
            if (apb.psel) begin
               ready      = 1'b1;
               pop        = 1'b1;
               rdata[7:0] = hold_q;
               state_d    = RD_DONE;
            end else begin
               state_d = IDLE;
            end
         end
         RD_DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A push reported while a pop is already committed is not an overrun.
   assign ovr_set = uart_irq & ~rx_fifo_empty & (state_q == IDLE) & ~hold_ld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         // NOTE: the hold register is reset so a read after reset never exposes stale data.
         hold_q   <= '0;
         tx_byte  <= '0;
         transmit <= 1'b0;
         ctrl_q   <= IRQ_EN_RST;
         rx_ovr_q <= 1'b0;
         tx_err_q <= 1'b0;
         irq      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q  <= state_d;
         if (hold_ld) hold_q  <= rx_byte;
         if (wr_tx)   tx_byte <= apb.pwdata[7:0];
         transmit <= wr_tx;
         if (ctrl_wr) ctrl_q  <= apb.pwdata[1:0];
         rx_ovr_q <= ovr_set    | (rx_ovr_q & ~ovr_clr);
         tx_err_q <= tx_err_set | (tx_err_q & ~err_clr);
         irq      <= (ctrl_q[CTRL_RX_IE] & ~rx_fifo_empty) |
                     (ctrl_q[CTRL_ERR_IE] & (rx_ovr_q | tx_err_q));
      end
   end

   // Bus-facing strobes are combinational, so they are forced low while reset is held.
   assign apb.pready   = rst_n & ready;
   assign apb.pslverr  = rst_n & slverr;
   assign apb.prdata   = rst_n ? rdata : '0;
   assign rx_fifo_pop  = rst_n & pop;

endmodule

// File: tb/tb_uart_apb_host.sv
// Self-checking bench for uart_apb_host: table-driven APB transfers through a
// scoreboard queue, plus hand sequences for irq, overrun, abort and reset.
module tb_uart_apb_host;
   import uart_apb_pkg::*;

   localparam int DATA_W = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_byte, rx_byte;
   logic       transmit, rx_fifo_pop, rx_fifo_empty, tx_fifo_full, busy, uart_irq, irq;

   uart_apb_host_if #(.DATA_W(DATA_W)) apb ();

   uart_apb_host #(.DATA_W(DATA_W), .IRQ_EN_RST(2'b00)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .apb           (apb),
      .tx_byte       (tx_byte),
      .transmit      (transmit),
      .rx_fifo_pop   (rx_fifo_pop),
      .rx_byte       (rx_byte),
      .rx_fifo_empty (rx_fifo_empty),
      .tx_fifo_full  (tx_fifo_full),
      .busy          (busy),
      .uart_irq      (uart_irq),
      .irq           (irq)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int viol     = 0;
   int pops     = 0;

   typedef struct {
      string       name;
      logic        wr;
      logic [1:0]  addr;
      logic [15:0] wdata;
      logic        rx_empty;
      logic [7:0]  rxb;
      logic        tx_full;
      logic        bsy;
      logic [15:0] exp_rdata;
      logic        exp_err;
      int          exp_waits;
      logic        exp_pop;
      logic        exp_tx;
   } vec_t;

   typedef struct {
      string       name;
      logic [15:0] rdata;
      logic        err;
      int          waits;
      logic        pop;
      logic        tx;
      logic [7:0]  txb;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Protocol invariants sampled every cycle, away from the active edge.
   always @(negedge clk) begin
      if (apb.pslverr && !apb.pready) viol++;
      if ((!apb.pready || !apb.psel) && apb.prdata != '0) viol++;
      if (transmit && rx_fifo_pop) viol++;
      if (rx_fifo_pop) pops++;
   end

   function automatic vec_t mk(input string name, input logic wr, input logic [1:0] addr,
                               input logic [15:0] wdata, input logic rx_empty, input logic [7:0] rxb,
                               input logic tx_full, input logic bsy, input logic [15:0] exp_rdata,
                               input logic exp_err, input int exp_waits, input logic exp_pop,
                               input logic exp_tx);
      vec_t v;
      v.name = name;  v.wr = wr;  v.addr = addr;  v.wdata = wdata;
      v.rx_empty = rx_empty;  v.rxb = rxb;  v.tx_full = tx_full;  v.bsy = bsy;
      v.exp_rdata = exp_rdata;  v.exp_err = exp_err;  v.exp_waits = exp_waits;
      v.exp_pop = exp_pop;  v.exp_tx = exp_tx;
      return v;
   endfunction

   task automatic apb_xfer(input logic wr, input logic [1:0] addr, input logic [15:0] wdata,
                           output logic [15:0] rdata, output logic err, output int waits,
                           output logic pop, output logic pop_wait, output logic tx1,
                           output logic [7:0] txb, output logic tx2);
      bit done;
      @(posedge clk); #1;
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = addr; apb.pwdata = wdata;
      @(posedge clk); #1;
      apb.penable = 1'b1;
      done = 1'b0; waits = 0; pop_wait = 1'b0; rdata = '0; err = 1'b0; pop = 1'b0;
      while (!done && waits < 8) begin
         @(negedge clk);
         if (apb.pready) begin
            rdata = apb.prdata; err = apb.pslverr; pop = rx_fifo_pop; done = 1'b1;
         end else begin
            pop_wait = pop_wait | rx_fifo_pop;
            waits++;
         end
      end
      @(posedge clk); #1;
      apb.psel = 1'b0; apb.penable = 1'b0;
      @(negedge clk);
      tx1 = transmit; txb = tx_byte;
      @(negedge clk);
      tx2 = transmit;
   endtask

   task automatic do_xfer(input string name, input logic wr, input logic [1:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp_rdata, input logic exp_err,
                          input int exp_waits, input logic exp_pop, input logic exp_tx);
      exp_t e, g;
      logic [15:0] rdata;
      logic err, pop, pop_wait, tx1, tx2;
      logic [7:0] txb;
      int waits;
      e.name = name; e.rdata = exp_rdata; e.err = exp_err; e.waits = exp_waits;
      e.pop = exp_pop; e.tx = exp_tx; e.txb = wdata[7:0];
      sb_q.push_back(e);
      apb_xfer(wr, addr, wdata, rdata, err, waits, pop, pop_wait, tx1, txb, tx2);
      g = sb_q.pop_front();
      check({g.name, ".prdata"},   32'(rdata),    32'(g.rdata));
      check({g.name, ".pslverr"},  32'(err),      32'(g.err));
      check({g.name, ".waits"},    32'(waits),    32'(g.waits));
      check({g.name, ".pop"},      32'(pop),      32'(g.pop));
      check({g.name, ".pop_wait"}, 32'(pop_wait), 32'(0));
      check({g.name, ".transmit"}, 32'(tx1),      32'(g.tx));
      check({g.name, ".tx_once"},  32'(tx2),      32'(0));
      if (g.tx) check({g.name, ".tx_byte"}, 32'(txb), 32'(g.txb));
   endtask

   task automatic check_quiet(input string name);
      check({name, ".pready"},  32'(apb.pready),  32'(0));
      check({name, ".pslverr"}, 32'(apb.pslverr), 32'(0));
      check({name, ".prdata"},  32'(apb.prdata),  32'(0));
      check({name, ".pop"},     32'(rx_fifo_pop), 32'(0));
      check({name, ".transmit"},32'(transmit),    32'(0));
      check({name, ".tx_byte"}, 32'(tx_byte),     32'(0));
      check({name, ".irq"},     32'(irq),         32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int pops_before;

      // Reset with a live-looking access on the bus: bus strobes must stay low.
      rst_n = 1'b0;
      apb.psel = 1'b1; apb.penable = 1'b1; apb.pwrite = 1'b0; apb.paddr = REG_UNMAPPED;
      apb.pwdata = '0;
      rx_byte = 8'h00; rx_fifo_empty = 1'b0; tx_fifo_full = 1'b0; busy = 1'b0; uart_irq = 1'b0;
      #12;
      check_quiet("reset");
      apb.psel = 1'b0; apb.penable = 1'b0;
      @(negedge clk); rx_fifo_empty = 1'b1;
      @(negedge clk); rst_n = 1'b1;

      vecs.push_back(mk("wr_data41",   1, REG_DATA,     16'h0041, 1, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 1));
      vecs.push_back(mk("rd_data5a",   0, REG_DATA,     16'h0000, 0, 8'h5A, 0, 0, 16'h005A, 0, 1, 1, 0));
      vecs.push_back(mk("rd_empty",    0, REG_DATA,     16'h0000, 1, 8'h99, 0, 0, 16'h0000, 1, 0, 0, 0));
      vecs.push_back(mk("wr_full",     1, REG_DATA,     16'h00AB, 1, 8'h00, 1, 0, 16'h0000, 1, 0, 0, 0));
      vecs.push_back(mk("st_txerr",    0, REG_STATUS,   16'h0000, 1, 8'h00, 1, 0, 16'h0012, 0, 0, 0, 0));
      vecs.push_back(mk("st_w1c",      1, REG_STATUS,   16'h0010, 1, 8'h00, 1, 0, 16'h0000, 0, 0, 0, 0));
      vecs.push_back(mk("st_cleared",  0, REG_STATUS,   16'h0000, 1, 8'h00, 1, 0, 16'h0002, 0, 0, 0, 0));
      vecs.push_back(mk("ctrl_wr3",    1, REG_CTRL,     16'h0003, 1, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0));
      vecs.push_back(mk("ctrl_rd3",    0, REG_CTRL,     16'h0000, 1, 8'h00, 0, 0, 16'h0003, 0, 0, 0, 0));
      vecs.push_back(mk("unm_rd",      0, REG_UNMAPPED, 16'h0000, 1, 8'h00, 0, 0, 16'h0000, 1, 0, 0, 0));
      vecs.push_back(mk("unm_wr",      1, REG_UNMAPPED, 16'hFFFF, 1, 8'h00, 0, 0, 16'h0000, 1, 0, 0, 0));
      vecs.push_back(mk("ctrl_keep",   0, REG_CTRL,     16'h0000, 1, 8'h00, 0, 0, 16'h0003, 0, 0, 0, 0));
      vecs.push_back(mk("ctrl_wr0",    1, REG_CTRL,     16'hFFFC, 1, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0));
      vecs.push_back(mk("ctrl_rd0",    0, REG_CTRL,     16'h0000, 1, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0));
      vecs.push_back(mk("st_live",     0, REG_STATUS,   16'h0000, 0, 8'h00, 0, 1, 16'h0005, 0, 0, 0, 0));
      vecs.push_back(mk("wr_data_c3",  1, REG_DATA,     16'hA5C3, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 1));

      foreach (vecs[i]) begin
         rx_fifo_empty = vecs[i].rx_empty; rx_byte = vecs[i].rxb;
         tx_fifo_full = vecs[i].tx_full; busy = vecs[i].bsy;
         do_xfer(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                 vecs[i].exp_err, vecs[i].exp_waits, vecs[i].exp_pop, vecs[i].exp_tx);
      end
      busy = 1'b0;

      // RX interrupt: one-cycle latency from rx_fifo_empty falling, masked by CTRL=0.
      rx_fifo_empty = 1'b1;
      do_xfer("ctrl_rxie", 1, REG_CTRL, 16'h0001, 16'h0000, 0, 0, 0, 0);
      @(negedge clk); check("irq_idle", 32'(irq), 32'(0));
      @(posedge clk); #1; rx_fifo_empty = 1'b0;
      @(negedge clk); check("irq_latency", 32'(irq), 32'(0));
      @(negedge clk); check("irq_rx", 32'(irq), 32'(1));
      do_xfer("ctrl_off", 1, REG_CTRL, 16'h0000, 16'h0000, 0, 0, 0, 0);
      check("irq_masked", 32'(irq), 32'(0));

      // Error interrupt from tx_err, cleared by W1C.
      do_xfer("ctrl_errie", 1, REG_CTRL, 16'h0002, 16'h0000, 0, 0, 0, 0);
      tx_fifo_full = 1'b1;
      do_xfer("wr_full2", 1, REG_DATA, 16'h0055, 16'h0000, 1, 0, 0, 0);
      check("irq_err", 32'(irq), 32'(1));
      do_xfer("st_w1c_err", 1, REG_STATUS, 16'h0010, 16'h0000, 0, 0, 0, 0);
      check("irq_err_clr", 32'(irq), 32'(0));
      tx_fifo_full = 1'b0;
      do_xfer("ctrl_off2", 1, REG_CTRL, 16'h0000, 16'h0000, 0, 0, 0, 0);

      // Overrun: sticky set, set beats a simultaneous W1C, then a clean clear.
      rx_fifo_empty = 1'b0;
      @(posedge clk); #1; uart_irq = 1'b1;
      @(posedge clk); #1; uart_irq = 1'b0;
      do_xfer("st_ovr", 0, REG_STATUS, 16'h0000, 16'h0009, 0, 0, 0, 0);
      uart_irq = 1'b1;
      do_xfer("st_w1c_race", 1, REG_STATUS, 16'h0008, 16'h0000, 0, 0, 0, 0);
      uart_irq = 1'b0;
      do_xfer("st_ovr_kept", 0, REG_STATUS, 16'h0000, 16'h0009, 0, 0, 0, 0);
      do_xfer("st_w1c_ovr", 1, REG_STATUS, 16'h0008, 16'h0000, 0, 0, 0, 0);
      do_xfer("st_ovr_clr", 0, REG_STATUS, 16'h0000, 16'h0001, 0, 0, 0, 0);

      // Aborted read: psel dropped in RD_WAIT, no pop, FSM back in IDLE.
      rx_byte = 8'h77;
      pops_before = pops;
      @(posedge clk); #1;
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = REG_DATA;
      @(posedge clk); #1; apb.penable = 1'b1;
      @(negedge clk); check("abort.wait", 32'(apb.pready), 32'(0));
      @(posedge clk); #1; apb.psel = 1'b0; apb.penable = 1'b0;
      @(negedge clk); check("abort.pready", 32'(apb.pready), 32'(0));
      @(negedge clk); check("abort.no_pop", 32'(pops - pops_before), 32'(0));
      do_xfer("abort.st_after", 0, REG_STATUS, 16'h0000, 16'h0001, 0, 0, 0, 0);
      do_xfer("abort.rd_after", 0, REG_DATA,   16'h0000, 16'h0077, 0, 1, 1, 0);

      // Reset asserted mid-RD_WAIT.
      rx_byte = 8'h3C;
      do_xfer("rst.ctrl_rxie", 1, REG_CTRL, 16'h0001, 16'h0000, 0, 0, 0, 0);
      @(negedge clk); check("rst.irq_before", 32'(irq), 32'(1));
      pops_before = pops;
      @(posedge clk); #1;
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = REG_DATA;
      @(posedge clk); #1; apb.penable = 1'b1;
      @(negedge clk); check("rst.wait", 32'(apb.pready), 32'(0));
      @(posedge clk); #2; rst_n = 1'b0;
      #1; check_quiet("rst_mid");
      @(negedge clk); apb.psel = 1'b0; apb.penable = 1'b0; rst_n = 1'b1;
      @(negedge clk); check("rst.no_pop", 32'(pops - pops_before), 32'(0));
      tx_fifo_full = 1'b1; busy = 1'b1;
      do_xfer("rst.st_live", 0, REG_STATUS, 16'h0000, 16'h0007, 0, 0, 0, 0);
      do_xfer("rst.ctrl",    0, REG_CTRL,   16'h0000, 16'h0000, 0, 0, 0, 0);
      tx_fifo_full = 1'b0; busy = 1'b0;
      do_xfer("rst.rd_data", 0, REG_DATA,   16'h0000, 16'h003C, 0, 1, 1, 0);

      check("protocol_invariants", 32'(viol), 32'(0));
      check("scoreboard_drained", 32'(sb_q.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_apb_host.md
UART_APB_HOST -- requirements
Module: uart_apb_host

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the APB data width (minimum 8).
REQ-002 The block SHALL have parameter IRQ_EN_RST, default 2'b00, giving the reset value of CTRL[1:0].
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have APB inputs psel, penable and pwrite (1 bit each), paddr (2 bits, word index) and pwdata (DATA_W bits).
REQ-006 The block SHALL have APB outputs prdata (DATA_W bits), pready (1 bit) and pslverr (1 bit).
REQ-007 The block SHALL have UART-side outputs tx_byte (8 bits), transmit (1 bit) and rx_fifo_pop (1 bit), which drive the UART FIFO host port.
REQ-008 The block SHALL have UART-side inputs rx_byte (8 bits, first-word-fall-through head), rx_fifo_empty, tx_fifo_full, busy and uart_irq (1 bit each).
REQ-009 The block SHALL have output irq, 1 bit: the maskable interrupt to the CPU.

Function
REQ-010 Register map SHALL be: 0 = DATA (R/W); 1 = STATUS (R, W1C); 2 = CTRL (R/W, bits[1:0]); 3 = unmapped.
REQ-011 Access FSM SHALL have states IDLE, RD_WAIT and RD_DONE; every access other than a DATA read SHALL complete in its first ACCESS cycle (pready=1).
REQ-012 A DATA read with rx_fifo_empty=0 SHALL follow this sequence:
- first ACCESS cycle: IDLE->RD_WAIT, pready=0, rx_byte latched into the hold register.
- second cycle: RD_DONE, pready=1, prdata={zeros,hold}, rx_fifo_pop=1 for exactly that cycle.
- next cycle: return to IDLE.
REQ-013 A DATA read with rx_fifo_empty=1 SHALL complete with zero wait states, pslverr=1, prdata=0 and no pop.
REQ-014 A DATA write with tx_fifo_full=0 SHALL complete with zero wait states; in the following cycle tx_byte=pwdata[7:0] and transmit=1 for exactly one cycle.
REQ-015 A DATA write with tx_fifo_full=1 SHALL set pslverr=1, produce no transmit pulse and set STATUS.tx_err.
REQ-016 STATUS SHALL read as: [0] !rx_fifo_empty; [1] tx_fifo_full; [2] busy; [3] rx_ovr (sticky); [4] tx_err (sticky); upper bits 0.
REQ-017 rx_ovr SHALL set when uart_irq=1 while rx_fifo_empty=0 and no pop is pending, i.e. a push into a non-drained FIFO was signalled.
REQ-018 A STATUS write SHALL clear bit 3 and/or bit 4 where the corresponding pwdata bit is 1.
REQ-019 If a sticky set event and a W1C clear of the same bit occur in the same cycle, the set SHALL win.
REQ-020 Accesses to paddr=3 SHALL complete with zero wait states, pslverr=1, prdata=0 and no side effects.
REQ-021 pslverr SHALL be asserted only in the cycle where pready=1.
REQ-022 prdata SHALL be 0 whenever pready=0 or psel=0.
REQ-023 irq SHALL be registered as (CTRL[0] & !rx_fifo_empty) | (CTRL[1] & (rx_ovr | tx_err)), with one-cycle latency.
REQ-024 psel deasserted while in RD_WAIT (aborted transfer) SHALL return the FSM to IDLE with no pop.
REQ-025 transmit and rx_fifo_pop SHALL never both be high in the same cycle.

Reset
REQ-026 While rst_n=0, the block SHALL drive: FSM=IDLE; prdata=0; pready=0; pslverr=0; transmit=0; rx_fifo_pop=0; tx_byte=0; irq=0; rx_ovr=0; tx_err=0; CTRL=IRQ_EN_RST; hold register=0.
REQ-027 Reset assertion SHALL take effect asynchronously, including mid-RD_WAIT, aborting any pending pop.
REQ-028 Deassertion SHALL be synchronised externally; the first access after deassertion SHALL behave normally.

Structure
REQ-029 A package uart_apb_pkg SHALL hold the register indices, the STATUS/CTRL bit positions and the FSM state encoding.
REQ-030 The block SHALL be a single module with no sub-module; the parent instantiates it beside the UART FIFO and connects the host ports.

Verification
REQ-031 The bench SHALL cover: write DATA 0x0041 with tx_fifo_full=0 -> pready in ACCESS, next cycle tx_byte=0x41 and transmit=1 for 1 cycle.
REQ-032 The bench SHALL cover: rx_byte=0x5A with rx_fifo_empty=0, read DATA -> one wait state, prdata=0x005A, rx_fifo_pop=1 in the pready cycle only.
REQ-033 The bench SHALL cover: read DATA with rx_fifo_empty=1 -> pslverr=1, prdata=0, no pop.
REQ-034 The bench SHALL cover: write DATA with tx_fifo_full=1 -> pslverr=1, STATUS reads 0x0012; then write STATUS 0x0010 -> STATUS reads 0x0002.
REQ-035 The bench SHALL cover: CTRL=0x1 with rx_fifo_empty falling -> irq=1 one cycle later; CTRL=0 -> irq=0.
REQ-036 The bench SHALL cover: rst_n pulsed low during RD_WAIT -> all outputs 0 immediately, no pop, next STATUS read returns live flags.
